// File: rtl/bw_clk_gclk_pkg.sv
// Shared types and defaults for the gclk center divider channels.
package bw_clk_gclk_pkg;

    // Per-channel run state.
    //   OFF   : output held low, counter parked at zero
    //   RUN   : dividing normally
    //   DRAIN : run request gone while high; finish the high phase, then stop
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    // Default divisor field width and ch_en synchroniser depth.
    localparam int DIVW_DEF        = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // A channel counts as running whenever it still owns its output clock.
    function automatic logic is_active(input ch_state_t s);
        return (s != OFF);
    endfunction

endpackage

// File: rtl/bw_clk_gclk_div_ch.sv
// One gclk channel: ch_en synchroniser, run/drain FSM, half-period counter
// and double-buffered divisor (pending -> active).
module bw_clk_gclk_div_ch
    import bw_clk_gclk_pkg::*;
#(
    parameter int DIVW        = DIVW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    input  logic            cfg_load_i,
    output logic            clk_o,
    output logic            sync_o,
    output logic            running_o,
    output logic            pend_o
);

    // Synchroniser chain for the asynchronous run request.
    logic [SYNC_STAGES-1:0] en_sync_q;
    logic                   en_s;

    // Channel state.
    ch_state_t       state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;
    logic            sync_q, sync_d;
    logic            running_q, running_d;

    // Configuration: pending divisor waits for a safe point, then becomes active.
    logic            pend_q, pend_d;
    logic [DIVW-1:0] div_pend_q, div_pend_d;
    logic [DIVW-1:0] div_act_q, div_act_d;

    // Combinational helpers.
    logic            hit_s;
    logic            fall_s;
    logic            apply_s;
    logic [DIVW-1:0] cnt_inc_s;

    assign en_s = en_sync_q[SYNC_STAGES-1];

    // Shift ch_en through the synchroniser flops.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            en_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], en_i};
        end
    end

    // Next-state logic for the run FSM, the counter and the divided clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_d     = clk_q;
        fall_s    = 1'b0;
        hit_s     = (cnt_q == div_act_q);
        cnt_inc_s = cnt_q + DIVW'(1'b1);

        case (state_q)
            OFF: begin
                // Output always restarts from low with a fresh half period.
                clk_d = 1'b0;
                cnt_d = {DIVW{1'b0}};
                if (en_s) begin
                    state_d = RUN;
                end else begin
                    state_d = OFF;
                end
            end

            RUN: begin
                if (!en_s && !clk_q) begin
                    // Stopping while low never produces a runt high pulse.
                    state_d = OFF;
                    clk_d   = 1'b0;
                    cnt_d   = {DIVW{1'b0}};
                end else begin
                    // Keep counting this cycle so the high phase is never cut short.
                    if (hit_s) begin
                        clk_d  = ~clk_q;
                        cnt_d  = {DIVW{1'b0}};
                        fall_s = clk_q;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                    if (en_s) begin
                        state_d = RUN;
                    end else if (hit_s) begin
                        // High phase finishes exactly as the request drops.
                        state_d = OFF;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Output is high throughout DRAIN, so a hit is always the falling toggle.
                if (hit_s) begin
                    clk_d  = 1'b0;
                    cnt_d  = {DIVW{1'b0}};
                    fall_s = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
                if (en_s) begin
                    // Request came back: resume without disturbing the phase.
                    state_d = RUN;
                end else if (hit_s) begin
                    state_d = OFF;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                state_d = OFF;
                clk_d   = 1'b0;
                cnt_d   = {DIVW{1'b0}};
            end
        endcase

        sync_d    = clk_d & ~clk_q;
        running_d = is_active(state_d);
    end

    // Pending/active divisor bookkeeping; a same-cycle load always wins.
    always_comb begin
        pend_d     = pend_q;
        div_pend_d = div_pend_q;
        div_act_d  = div_act_q;
        apply_s    = (state_q == OFF) || fall_s;

        if (apply_s && pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
        end else begin
            div_act_d = div_act_q;
        end

        if (cfg_load_i) begin
            pend_d     = 1'b1;
            div_pend_d = div_i;
        end else begin
            div_pend_d = div_pend_q;
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_q   <= OFF;
            cnt_q     <= {DIVW{1'b0}};
            clk_q     <= 1'b0;
            sync_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            sync_q    <= sync_d;
            running_q <= running_d;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            pend_q     <= 1'b0;
            div_pend_q <= {DIVW{1'b0}};
            div_act_q  <= {DIVW{1'b0}};
        end else begin
            pend_q     <= pend_d;
            div_pend_q <= div_pend_d;
            div_act_q  <= div_act_d;
        end
    end

    assign clk_o     = clk_q;
    assign sync_o    = sync_q;
    assign running_o = running_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/bw_clk_gclk_center_nch.sv
// gclk center driver: NCH independent divided, gated clocks from one root clock.
module bw_clk_gclk_center_nch
    import bw_clk_gclk_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int DIVW        = DIVW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                arst_l,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH*DIVW-1:0] ch_div,
    input  logic                cfg_load,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      sync_out,
    output logic [NCH-1:0]      ch_running,
    output logic                cfg_busy
);

    logic [NCH-1:0] pend_s;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        bw_clk_gclk_div_ch #(
            .DIVW        (DIVW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .arst_l     (arst_l),
            .en_i       (ch_en[i]),
            .div_i      (ch_div[i*DIVW +: DIVW]),
            .cfg_load_i (cfg_load),
            .clk_o      (clk_out[i]),
            .sync_o     (sync_out[i]),
            .running_o  (ch_running[i]),
            .pend_o     (pend_s[i])
        );
    end

    // Busy while any channel still holds an unapplied divisor (pend bits are flops).
    assign cfg_busy = |pend_s;

endmodule

// File: tb/tb_bw_clk_gclk_center_nch.sv
// Self-checking bench for bw_clk_gclk_center_nch (NCH=3, DIVW=4, SYNC_STAGES=2).
module tb_bw_clk_gclk_center_nch;

    localparam int NCH  = 3;
    localparam int DIVW = 4;
    localparam int SS   = 2;
    localparam int MAXK = 80;

    logic                clk = 1'b0;
    logic                arst_l;
    logic [NCH-1:0]      ch_en;
    logic [NCH*DIVW-1:0] ch_div;
    logic                cfg_load;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      sync_out;
    logic [NCH-1:0]      ch_running;
    logic                cfg_busy;

    bw_clk_gclk_center_nch #(
        .NCH         (NCH),
        .DIVW        (DIVW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .arst_l     (arst_l),
        .ch_en      (ch_en),
        .ch_div     (ch_div),
        .cfg_load   (cfg_load),
        .clk_out    (clk_out),
        .sync_out   (sync_out),
        .ch_running (ch_running),
        .cfg_busy   (cfg_busy)
    );

    always #5 clk = ~clk;

    // Observation word: {clk_out, sync_out, ch_running, cfg_busy}.
    typedef logic [3*NCH:0] obs_t;

    // Steady-state table: divisors plus hand-derived first rise edge and period.
    typedef struct {
        logic [NCH*DIVW-1:0] div;
        int rise0; int rise1; int rise2;
        int per0;  int per1;  int per2;
        int ncyc;
    } vec_t;

    vec_t vecs [3];

    obs_t exp_q [$];
    logic [NCH-1:0]      en_v [MAXK];
    logic                ld_v [MAXK];
    logic [NCH*DIVW-1:0] dv_v [MAXK];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic obs_t observe();
        return {clk_out, sync_out, ch_running, cfg_busy};
    endfunction

    function automatic obs_t mk(input logic [NCH-1:0] c, input logic [NCH-1:0] s,
                                input logic [NCH-1:0] r, input logic b);
        return {c, s, r, b};
    endfunction

    // Ideal divided waveform: high for the first half of each period from rise r.
    function automatic logic wv(input int k, input int r, input int p);
        if (k < r) return 1'b0;
        return (((k - r) % p) < (p / 2));
    endfunction

    function automatic logic sv(input int k, input int r, input int p);
        if (k < r) return 1'b0;
        return (((k - r) % p) == 0);
    endfunction

    task automatic check(input string name, input int k, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s k=%0d got {clk,sync,run,busy}=%b want %b", name, k, act, exp);
        end
    endtask

    task automatic reset_dut();
        arst_l   = 1'b0;
        ch_en    = '0;
        cfg_load = 1'b0;
        ch_div   = '0;
        repeat (2) @(posedge clk);
        #3;
        arst_l = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 0, observe(), '0);
    endtask

    // Load divisors while all channels are OFF: busy for one cycle, then applied.
    task automatic preload(input logic [NCH*DIVW-1:0] d);
        ch_div   = d;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        check("cfg_busy_set", 0, observe(), mk(3'b000, 3'b000, 3'b000, 1'b1));
        @(posedge clk);
        #1;
        check("cfg_busy_clear_off", 0, observe(), '0);
    endtask

    task automatic clear_stim(input logic [NCH-1:0] en, input logic [NCH*DIVW-1:0] d);
        for (int k = 0; k < MAXK; k++) begin
            en_v[k] = en;
            ld_v[k] = 1'b0;
            dv_v[k] = d;
        end
    endtask

    // Drive the stimulus tables edge by edge and compare against the scoreboard.
    task automatic run_seq(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            ch_en    = en_v[k];
            cfg_load = ld_v[k];
            ch_div   = dv_v[k];
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL %s k=%0d scoreboard empty", name, k);
            end else begin
                check(name, k, observe(), exp_q.pop_front());
            end
        end
        ch_en    = '0;
        cfg_load = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s leftover expectations %0d", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic found;
        logic [NCH-1:0] c, s, r;
        logic b;

        vecs[0] = '{div: 12'h310, rise0: 3,  rise1: 4,  rise2: 6, per0: 2,  per1: 4,  per2: 8,  ncyc: 30};
        vecs[1] = '{div: 12'h502, rise0: 5,  rise1: 3,  rise2: 8, per0: 6,  per1: 2,  per2: 12, ncyc: 40};
        vecs[2] = '{div: 12'h47F, rise0: 18, rise1: 10, rise2: 7, per0: 32, per1: 16, per2: 10, ncyc: 75};

        // All channels started together; rises, periods and sync pulses from the table.
        for (int v = 0; v < 3; v++) begin
            reset_dut();
            preload(vecs[v].div);
            clear_stim(3'b111, vecs[v].div);
            for (int k = 0; k < vecs[v].ncyc; k++) begin
                c = {wv(k, vecs[v].rise2, vecs[v].per2), wv(k, vecs[v].rise1, vecs[v].per1),
                     wv(k, vecs[v].rise0, vecs[v].per0)};
                s = {sv(k, vecs[v].rise2, vecs[v].per2), sv(k, vecs[v].rise1, vecs[v].per1),
                     sv(k, vecs[v].rise0, vecs[v].per0)};
                r = (k >= SS) ? 3'b111 : 3'b000;
                exp_q.push_back(mk(c, s, r, 1'b0));
            end
            run_seq($sformatf("steady_row%0d", v), vecs[v].ncyc);
        end

        // Asynchronous reset while a channel output is high.
        reset_dut();
        preload(12'h300);
        ch_en = 3'b100;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (clk_out[2]) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_mis++;
            $display("FAIL reset_wait_high got clk_out=%b want bit2 high within 40 cycles", clk_out);
        end
        #2;
        arst_l = 1'b0;
        ch_en  = '0;
        #1;
        check("async_reset", 0, observe(), '0);
        #2;
        arst_l = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("after_reset_idle", k, observe(), '0);
        end

        // Channel 1, d=3: request dropped one cycle into the high phase.
        reset_dut();
        preload(12'h030);
        clear_stim(3'b010, 12'h030);
        for (int k = 7; k < MAXK; k++) en_v[k] = 3'b000;
        for (int k = 0; k < 25; k++) begin
            c = {1'b0, (k >= 6 && k <= 9), 1'b0};
            s = {1'b0, (k == 6), 1'b0};
            r = {1'b0, (k >= 2 && k <= 9), 1'b0};
            exp_q.push_back(mk(c, s, r, 1'b0));
        end
        run_seq("drain_from_high", 25);

        // Channel 1, d=3: request dropped during the low phase, no runt pulse.
        reset_dut();
        preload(12'h030);
        clear_stim(3'b010, 12'h030);
        for (int k = 11; k < MAXK; k++) en_v[k] = 3'b000;
        for (int k = 0; k < 25; k++) begin
            c = {1'b0, (k >= 6 && k <= 9), 1'b0};
            s = {1'b0, (k == 6), 1'b0};
            r = {1'b0, (k >= 2 && k <= 12), 1'b0};
            exp_q.push_back(mk(c, s, r, 1'b0));
        end
        run_seq("stop_from_low", 25);

        // Channel 0, d=1: one-cycle drop lands in DRAIN, phase must be untouched.
        reset_dut();
        preload(12'h001);
        clear_stim(3'b001, 12'h001);
        en_v[7] = 3'b000;
        for (int k = 0; k < 30; k++) begin
            c = {2'b00, wv(k, 4, 4)};
            s = {2'b00, sv(k, 4, 4)};
            r = {2'b00, (k >= 2)};
            exp_q.push_back(mk(c, s, r, 1'b0));
        end
        run_seq("drain_reenable", 30);

        // Channel 0, d=1 -> 3 loaded during the high phase, applied at the next fall.
        reset_dut();
        preload(12'h001);
        clear_stim(3'b001, 12'h001);
        ld_v[9] = 1'b1;
        dv_v[9] = 12'h003;
        for (int k = 0; k < 40; k++) begin
            if (k < 10) begin
                c = {2'b00, wv(k, 4, 4)};
                s = {2'b00, sv(k, 4, 4)};
            end else begin
                c = {2'b00, wv(k, 14, 8)};
                s = {2'b00, sv(k, 14, 8)};
            end
            r = {2'b00, (k >= 2)};
            b = (k == 9);
            exp_q.push_back(mk(c, s, r, b));
        end
        run_seq("reconfig_d3", 40);

        // Channel 0: load d=2, then d=5 on the apply cycle; d=5 lands one fall later.
        reset_dut();
        preload(12'h001);
        clear_stim(3'b001, 12'h001);
        ld_v[9]  = 1'b1;
        dv_v[9]  = 12'h002;
        ld_v[10] = 1'b1;
        dv_v[10] = 12'h005;
        for (int k = 0; k < 45; k++) begin
            if (k < 10) begin
                c = {2'b00, wv(k, 4, 4)};
                s = {2'b00, sv(k, 4, 4)};
            end else if (k < 16) begin
                c = {2'b00, wv(k, 13, 6)};
                s = {2'b00, sv(k, 13, 6)};
            end else begin
                c = {2'b00, wv(k, 22, 12)};
                s = {2'b00, sv(k, 22, 12)};
            end
            r = {2'b00, (k >= 2)};
            b = (k >= 9 && k <= 15);
            exp_q.push_back(mk(c, s, r, b));
        end
        run_seq("reconfig_overlap", 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
